branch_predict_ctrl: RTL and testbench
======================================

Name: branch_predict_ctrl

Overview:
- Branch prediction and misprediction-recovery controller for the in-order pipeline.
- Holds a table of 2-bit saturating counters, gives the fetch stage a taken/not-taken prediction, and takes resolved outcomes from the execute-stage branch unit (beq/bne compare result plus sign-extended offset).
- On a mispredict it issues a one-cycle redirect and holds a multi-cycle pipeline flush.
- Keeps branch and mispredict statistics counters.

Parameters:
- ADDR_W, 64, PC/address width
- IDX_W, 6, log2 of table entries; index = pc[IDX_W+1:2]
- FLUSH_CYC, 2, cycles o_flush is held after a mispredict (≥1)
- CNT_W, 32, width of statistics counters

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_if_pc  in  ADDR_W  fetch-stage PC to predict
- o_pred_taken  out  1  combinational prediction for i_if_pc (counter[1])
- i_res_valid  in  1  execute stage holds a resolved conditional branch this cycle
- i_res_pc  in  ADDR_W  PC of the resolved branch
- i_res_taken  in  1  actual outcome (branch unit br)
- i_res_pred  in  1  prediction that was made for this branch at fetch
- i_res_off  in  ADDR_W  sign-extended byte offset (branch unit br_addr)
- o_redirect_valid  out  1  one-cycle pulse: fetch must load o_redirect_pc
- o_redirect_pc  out  ADDR_W  correct next PC
- o_flush  out  1  squash younger instructions in IF/ID
- o_br_cnt  out  CNT_W  branches resolved
- o_miss_cnt  out  CNT_W  mispredicts

Behaviour:
- Reset (async, i_rst_n=0):
  - all table entries = 2'b01 (weakly not-taken)
  - FSM = IDLE, flush counter = 0
  - o_redirect_valid = 0, o_redirect_pc = 0, o_flush = 0
  - o_br_cnt = 0, o_miss_cnt = 0
  - Reset mid-flush aborts the flush immediately.
- Prediction: o_pred_taken = table[i_if_pc[IDX_W+1:2]][1], purely combinational, zero latency.
- Accepted resolution: i_res_valid=1 and FSM=IDLE.
  - During FLUSH, i_res_valid is ignored (wrong-path instruction): no table update, no counter change, no redirect.
- Table update, registered, on an accepted resolution, at index i_res_pc[IDX_W+1:2]:
  - taken: counter increments, saturating at 2'b11
  - not taken: counter decrements, saturating at 2'b00
- Same-cycle read and update of the same index: o_pred_taken reflects the pre-update value (no bypass).
- Mispredict = accepted resolution with i_res_taken != i_res_pred.
- Redirect target, registered, 1-cycle latency:
  - i_res_taken=1: i_res_pc + i_res_off (mod 2^ADDR_W; a negative offset wraps naturally)
  - i_res_taken=0: i_res_pc + 4
- FSM:
  - IDLE: on a mispredict, next cycle assert o_redirect_valid=1 for exactly one cycle with o_redirect_pc, set o_flush=1, load flush counter = FLUSH_CYC-1, go to FLUSH.
  - FLUSH: o_flush=1. If counter==0, go to IDLE (o_flush=0 next cycle); else decrement.
  - o_flush is therefore high for exactly FLUSH_CYC cycles, starting the cycle after the mispredicting resolution.
- o_redirect_pc holds its last value when o_redirect_valid=0.
- Statistics, on an accepted resolution:
  - o_br_cnt += 1
  - o_miss_cnt += 1 on a mispredict
  - both saturate at all-ones (no wrap)
- A correctly predicted branch produces no redirect and no flush.

Decomposition:
- Shared package: 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11), FSM state enum {IDLE, FLUSH}, the INST_BYTES=4 constant.
- One natural sub-module: sat_counter2. It is a 2-bit saturating increment/decrement function; use it once per table write port, or as a function.

Test Plan:
- Reset, then i_if_pc=0x100 → o_pred_taken=0. All outputs 0.
- Resolve pc=0x100, taken=1, pred=0, off=0x20 → next cycle o_redirect_valid=1, o_redirect_pc=0x120; o_flush high for 2 cycles; o_miss_cnt=1, o_br_cnt=1; entry 0x100 becomes 10, so o_pred_taken=1.
- Two further taken resolutions of pc=0x100 with pred=1 (non-mispredicts) → entry saturates at 11. A not-taken resolution with pred=1 gives redirect to 0x104 and entry 10.
- Negative offset: pc=0x200, off=0xFFFF_FFFF_FFFF_FFF0, taken=1, pred=0 → o_redirect_pc=0x1F0.
- i_res_valid pulsed during the FLUSH window → ignored: counters and table unchanged, no second redirect.
- Assert i_rst_n low during FLUSH → o_flush=0 immediately and the table returns to 01. Same-cycle predict/update of one index → prediction shows the old value.

Source files
------------

// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and constants for the branch prediction controller:
// 2-bit counter encodings, recovery FSM states and instruction size.
package branch_predict_ctrl_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int INST_BYTES = 4;

endpackage

// File: rtl/branch_predict_ctrl_sat_counter2.sv
// 2-bit saturating up/down counter step: increments toward strongly-taken
// on a taken outcome, decrements toward strongly-not-taken otherwise.
module branch_predict_ctrl_sat_counter2
    import branch_predict_ctrl_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       inc,
    output logic [1:0] nxt
);

    always_comb begin
        nxt = cnt;
        if (inc) begin
            if (cnt != ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) nxt = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor with 2-bit counter table, mispredict redirect/flush
// sequencing and saturating branch/mispredict statistics.
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 64,
    parameter int IDX_W     = 6,
    parameter int FLUSH_CYC = 2,
    parameter int CNT_W     = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_if_pc,
    output logic              o_pred_taken,
    input  logic              i_res_valid,
    input  logic [ADDR_W-1:0] i_res_pc,
    input  logic              i_res_taken,
    input  logic              i_res_pred,
    input  logic [ADDR_W-1:0] i_res_off,
    output logic              o_redirect_valid,
    output logic [ADDR_W-1:0] o_redirect_pc,
    output logic              o_flush,
    output logic [CNT_W-1:0]  o_br_cnt,
    output logic [CNT_W-1:0]  o_miss_cnt
);

    localparam int TBL_N = 1 << IDX_W;
    localparam int FC_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    logic [1:0]        pht [TBL_N];
    state_e            state, state_n;
    logic [FC_W-1:0]   flush_cnt, flush_cnt_n;
    logic [IDX_W-1:0]  if_idx, res_idx;
    logic [1:0]        upd_val;
    logic              accept, mispredict;
    logic [ADDR_W-1:0] target;
    logic              unused_if_pc;

    assign if_idx       = i_if_pc[IDX_W+1:2];
    assign res_idx      = i_res_pc[IDX_W+1:2];
    assign unused_if_pc = ^{i_if_pc[ADDR_W-1:IDX_W+2], i_if_pc[1:0]};

    // Resolutions arriving while flushing belong to squashed wrong-path work.
    assign accept       = i_res_valid && (state == IDLE);
    assign mispredict   = accept && (i_res_taken != i_res_pred);
    assign target       = i_res_taken ? (i_res_pc + i_res_off)
                                      : (i_res_pc + ADDR_W'(INST_BYTES));

    assign o_pred_taken = pht[if_idx][1];
    assign o_flush      = (state == FLUSH);

    branch_predict_ctrl_sat_counter2 u_sat (
        .cnt (pht[res_idx]),
        .inc (i_res_taken),
        .nxt (upd_val)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < TBL_N; i++) pht[i] <= WNT;
        end else if (accept) begin
            pht[res_idx] <= upd_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            flush_cnt <= '0;
        end else begin
            state     <= state_n;
            flush_cnt <= flush_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        flush_cnt_n = flush_cnt;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    state_n     = FLUSH;
                    flush_cnt_n = FC_W'(FLUSH_CYC - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) state_n = IDLE;
                else                 flush_cnt_n = flush_cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_br_cnt         <= '0;
            o_miss_cnt       <= '0;
        end else begin
            o_redirect_valid <= mispredict;
            if (mispredict) o_redirect_pc <= target;
            if (accept && (o_br_cnt != '1)) o_br_cnt <= o_br_cnt + 1'b1;
            if (mispredict && (o_miss_cnt != '1)) o_miss_cnt <= o_miss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: a vector table pushed through
// a scoreboard queue, plus a hand-written reset-during-flush sequence.
module tb_branch_predict_ctrl;

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic        t;
        logic        p;
        logic [63:0] off;
        logic [63:0] if_pc;
        logic        pred_now;
        logic        rv;
        logic [63:0] rpc;
        logic        fl;
        logic [31:0] br;
        logic [31:0] miss;
        logic        pred_after;
    } vec_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [63:0] i_if_pc;
    logic        o_pred_taken;
    logic        i_res_valid;
    logic [63:0] i_res_pc;
    logic        i_res_taken;
    logic        i_res_pred;
    logic [63:0] i_res_off;
    logic        o_redirect_valid;
    logic [63:0] o_redirect_pc;
    logic        o_flush;
    logic [31:0] o_br_cnt;
    logic [31:0] o_miss_cnt;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [17];
    vec_t sb_q [$];

    branch_predict_ctrl dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_if_pc          (i_if_pc),
        .o_pred_taken     (o_pred_taken),
        .i_res_valid      (i_res_valid),
        .i_res_pc         (i_res_pc),
        .i_res_taken      (i_res_taken),
        .i_res_pred       (i_res_pred),
        .i_res_off        (i_res_off),
        .o_redirect_valid (o_redirect_valid),
        .o_redirect_pc    (o_redirect_pc),
        .o_flush          (o_flush),
        .o_br_cnt         (o_br_cnt),
        .o_miss_cnt       (o_miss_cnt)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(logic v, logic [63:0] pc, logic t, logic p,
                                logic [63:0] off, logic [63:0] if_pc,
                                logic pred_now, logic rv, logic [63:0] rpc,
                                logic fl, logic [31:0] br, logic [31:0] miss,
                                logic pred_after);
        vec_t r;
        r.v = v; r.pc = pc; r.t = t; r.p = p; r.off = off; r.if_pc = if_pc;
        r.pred_now = pred_now; r.rv = rv; r.rpc = rpc; r.fl = fl;
        r.br = br; r.miss = miss; r.pred_after = pred_after;
        return r;
    endfunction

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one resolution slot; the combinational prediction is checked
    // before the edge so a same-index update must not be visible yet.
    task automatic applyStimulus(input vec_t s);
        i_res_valid = s.v;
        i_res_pc    = s.pc;
        i_res_taken = s.t;
        i_res_pred  = s.p;
        i_res_off   = s.off;
        i_if_pc     = s.if_pc;
        #1;
        compare("pred_now", 64'(o_pred_taken), 64'(s.pred_now));
        sb_q.push_back(s);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (sb_q.size() == 0) begin
            compare("sb_empty", 64'(1), 64'(0));
            return;
        end
        e = sb_q.pop_front();
        compare("redirect_valid", 64'(o_redirect_valid), 64'(e.rv));
        compare("redirect_pc",    o_redirect_pc,         e.rpc);
        compare("flush",          64'(o_flush),          64'(e.fl));
        compare("br_cnt",         64'(o_br_cnt),         64'(e.br));
        compare("miss_cnt",       64'(o_miss_cnt),       64'(e.miss));
        compare("pred_after",     64'(o_pred_taken),     64'(e.pred_after));
    endtask

    initial begin
        //             v  pc     t  p  off                     if_pc  now rv rpc    fl br miss aft
        vecs[0]  = mk(1, 'h100, 1, 0, 'h20,                   'h100, 0,  1, 'h120, 1, 1, 1, 1);
        vecs[1]  = mk(0, 'h0,   0, 0, 'h0,                    'h100, 1,  0, 'h120, 1, 1, 1, 1);
        vecs[2]  = mk(0, 'h0,   0, 0, 'h0,                    'h100, 1,  0, 'h120, 0, 1, 1, 1);
        vecs[3]  = mk(1, 'h100, 1, 1, 'h20,                   'h100, 1,  0, 'h120, 0, 2, 1, 1);
        vecs[4]  = mk(1, 'h100, 1, 1, 'h20,                   'h100, 1,  0, 'h120, 0, 3, 1, 1);
        vecs[5]  = mk(1, 'h100, 0, 1, 'h20,                   'h100, 1,  1, 'h104, 1, 4, 2, 1);
        vecs[6]  = mk(1, 'h100, 0, 0, 'h20,                   'h100, 1,  0, 'h104, 1, 4, 2, 1);
        vecs[7]  = mk(1, 'h100, 1, 0, 'h20,                   'h100, 1,  0, 'h104, 0, 4, 2, 1);
        vecs[8]  = mk(1, 'h200, 1, 0, 64'hFFFF_FFFF_FFFF_FFF0, 'h200, 1,  1, 'h1F0, 1, 5, 3, 1);
        vecs[9]  = mk(0, 'h0,   0, 0, 'h0,                    'h104, 0,  0, 'h1F0, 1, 5, 3, 0);
        vecs[10] = mk(0, 'h0,   0, 0, 'h0,                    'h104, 0,  0, 'h1F0, 0, 5, 3, 0);
        vecs[11] = mk(1, 'h104, 0, 0, 'h0,                    'h104, 0,  0, 'h1F0, 0, 6, 3, 0);
        vecs[12] = mk(1, 'h108, 1, 1, 'h8,                    'h108, 0,  0, 'h1F0, 0, 7, 3, 1);
        vecs[13] = mk(1, 'h104, 0, 0, 'h0,                    'h104, 0,  0, 'h1F0, 0, 8, 3, 0);
        vecs[14] = mk(1, 'h104, 1, 0, 'h40,                   'h104, 0,  1, 'h144, 1, 9, 4, 0);
        vecs[15] = mk(0, 'h0,   0, 0, 'h0,                    'h104, 0,  0, 'h144, 1, 9, 4, 0);
        vecs[16] = mk(0, 'h0,   0, 0, 'h0,                    'h104, 0,  0, 'h144, 0, 9, 4, 0);

        i_rst_n     = 1'b0;
        i_res_valid = 1'b0;
        i_res_pc    = '0;
        i_res_taken = 1'b0;
        i_res_pred  = 1'b0;
        i_res_off   = '0;
        i_if_pc     = 64'h100;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        compare("rst_pred",   64'(o_pred_taken),     64'(0));
        compare("rst_rv",     64'(o_redirect_valid), 64'(0));
        compare("rst_rpc",    o_redirect_pc,         64'(0));
        compare("rst_flush",  64'(o_flush),          64'(0));
        compare("rst_br",     64'(o_br_cnt),         64'(0));
        compare("rst_miss",   64'(o_miss_cnt),       64'(0));
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            @(posedge i_clk);
            @(negedge i_clk);
            checkOutput();
        end

        // Start a flush, then pull reset while it is in progress.
        applyStimulus(mk(1, 'h100, 0, 1, 'h0, 'h100, 1, 1, 'h104, 1, 10, 5, 1));
        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput();
        i_res_valid = 1'b0;
        i_rst_n     = 1'b0;
        #1;
        compare("midrst_flush", 64'(o_flush),          64'(0));
        compare("midrst_rv",    64'(o_redirect_valid), 64'(0));
        compare("midrst_rpc",   o_redirect_pc,         64'(0));
        compare("midrst_br",    64'(o_br_cnt),         64'(0));
        compare("midrst_miss",  64'(o_miss_cnt),       64'(0));
        compare("midrst_pred0", 64'(o_pred_taken),     64'(0));
        i_if_pc = 64'h108;
        #1;
        compare("midrst_pred2", 64'(o_pred_taken),     64'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        compare("post_flush",   64'(o_flush),          64'(0));
        compare("post_rv",      64'(o_redirect_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
